// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared gray/binary helpers and pointer constants for the async FIFO
package fifo_pkg;

    localparam int DEFAULT_PTR_WIDTH = 3;
    localparam int PTR_MAX_W         = 32;

    // Callers zero-extend narrower pointers; leading zeros keep both conversions exact.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_gray2bin_conv.sv
// rtl/fifo_wr_ptr_ctrl_gray2bin_conv.sv - combinational gray-to-binary decoder, shared by both FIFO sides
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PTR_WIDTH + 1
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o = WIDTH'(gray2bin(PTR_MAX_W'(gray_i)));

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// rtl/fifo_wr_ptr_ctrl.sv - write-side pointer, gray pointer and full/level flags of the async FIFO
module fifo_wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH,
    parameter int AFULL_TH  = 6
) (
    input  logic                 w_clk,
    input  logic                 w_rstn,
    input  logic                 w_inc,
    input  logic [PTR_WIDTH:0]   wq2_rptr,
    output logic                 w_en,
    output logic [PTR_WIDTH-1:0] w_addr,
    output logic [PTR_WIDTH:0]   w_ptr_gray,
    output logic                 w_full,
    output logic                 w_almost_full,
    output logic [PTR_WIDTH:0]   w_level,
    output logic                 w_ovf
);

    localparam int PW = PTR_WIDTH;

    logic [PW:0] bin_q, bin_d;
    logic [PW:0] gray_q, gray_d;
    logic [PW:0] level_q, level_d;
    logic [PW:0] rbin;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        ovf_q, ovf_d;
    logic        accept;

    gray2bin_conv #(
        .WIDTH (PW + 1)
    ) u_rptr_dec (
        .gray_i (wq2_rptr),
        .bin_o  (rbin)
    );

    // Flags are computed from bin_d so they already include this cycle's write.
    always_comb begin
        accept  = w_inc & ~full_q;
        bin_d   = bin_q + {{PW{1'b0}}, accept};
        gray_d  = (PW + 1)'(bin2gray(PTR_MAX_W'(bin_d)));
        full_d  = (gray_d == {~wq2_rptr[PW -: 2], wq2_rptr[PW-2:0]});
        level_d = bin_d - rbin;
        afull_d = (level_d >= (PW + 1)'(AFULL_TH));
        ovf_d   = w_inc & full_q;
    end

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_en          = w_inc & ~full_q;
    assign w_addr        = bin_q[PW-1:0];
    assign w_ptr_gray    = gray_q;
    assign w_full        = full_q;
    assign w_almost_full = afull_q;
    assign w_level       = level_q;
    assign w_ovf         = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb/tb_fifo_wr_ptr_ctrl.sv - randomized and directed bench for fifo_wr_ptr_ctrl against a count-based model
module tb_fifo_wr_ptr_ctrl;

    localparam int PW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic          w_clk = 1'b0;
    logic          w_rstn;
    logic          w_inc;
    logic [PW:0]   wq2_rptr;
    logic          w_en;
    logic [PW-1:0] w_addr;
    logic [PW:0]   w_ptr_gray;
    logic          w_full;
    logic          w_almost_full;
    logic [PW:0]   w_level;
    logic          w_ovf;

    fifo_wr_ptr_ctrl #(
        .PTR_WIDTH (PW),
        .AFULL_TH  (AF)
    ) dut (
        .w_clk         (w_clk),
        .w_rstn        (w_rstn),
        .w_inc         (w_inc),
        .wq2_rptr      (wq2_rptr),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .w_ptr_gray    (w_ptr_gray),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_ovf         (w_ovf)
    );

    always #5 w_clk = ~w_clk;

    int total = 0;
    int bad   = 0;

    // Model: counts of accepted writes and of reads visible to the write side.
    int wcnt;
    int rcnt;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;

    function automatic logic [PW:0] gray_of(input int n);
        int m;
        m = n % (2 * DEPTH);
        return (PW + 1)'(m ^ (m / 2));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wcnt    = 0;
        rcnt    = 0;
        m_level = 0;
        m_full  = 0;
        m_afull = 0;
        m_ovf   = 0;
    endtask

    // Entered at a falling edge; drives inputs, checks, clocks once, checks again.
    task automatic cycle(input bit inc, input bit radv);
        logic [PW:0] old_gray;
        bit acc;
        if (radv && rcnt < wcnt) rcnt++;
        w_inc    = inc;
        wq2_rptr = gray_of(rcnt);
        #1;
        check_eq("w_en", w_en, inc && !m_full);
        check_eq("w_addr", w_addr, wcnt % DEPTH);
        old_gray = w_ptr_gray;
        @(posedge w_clk);
        acc     = inc && !m_full;
        m_ovf   = inc && m_full;
        wcnt    = wcnt + int'(acc);
        m_level = wcnt - rcnt;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= AF);
        @(negedge w_clk);
        check_eq("w_ptr_gray", w_ptr_gray, gray_of(wcnt));
        check_eq("w_level", w_level, m_level);
        check_eq("w_full", w_full, m_full);
        check_eq("w_almost_full", w_almost_full, m_afull);
        check_eq("w_ovf", w_ovf, m_ovf);
        check_eq("gray_one_bit", ($countones(w_ptr_gray ^ old_gray) <= 1), 1);
    endtask

    task automatic mid_clock_reset();
        @(posedge w_clk);
        #2;
        w_inc  = 1'b1;
        w_rstn = 1'b0;
        #1;
        check_eq("rst_gray", w_ptr_gray, 0);
        check_eq("rst_level", w_level, 0);
        check_eq("rst_full", w_full, 0);
        check_eq("rst_afull", w_almost_full, 0);
        check_eq("rst_ovf", w_ovf, 0);
        check_eq("rst_en", w_en, 1);
        check_eq("rst_addr", w_addr, 0);
        model_reset();
        wq2_rptr = '0;
        w_inc    = 1'b0;
        @(negedge w_clk);
        @(negedge w_clk);
        w_rstn = 1'b1;
    endtask

    logic [PW:0] fill_gray [DEPTH] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    initial begin
        model_reset();
        w_rstn   = 1'b0;
        w_inc    = 1'b0;
        wq2_rptr = '0;
        repeat (2) @(negedge w_clk);
        w_rstn = 1'b1;

        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        mid_clock_reset();

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0);
            check_eq("fill_gray", w_ptr_gray, fill_gray[i]);
            check_eq("fill_level", w_level, i + 1);
            check_eq("fill_afull", w_almost_full, (i + 1) >= AF);
        end
        check_eq("fill_full", w_full, 1);
        check_eq("fill_addr_wrap", w_addr, 0);

        cycle(1, 0);
        check_eq("ovf_1", w_ovf, 1);
        cycle(1, 0);
        check_eq("ovf_2", w_ovf, 1);
        check_eq("ovf_gray_held", w_ptr_gray, 4'hC);
        cycle(0, 0);
        check_eq("ovf_end", w_ovf, 0);

        cycle(0, 1);
        check_eq("drain_full", w_full, 0);
        check_eq("drain_level", w_level, 7);
        cycle(1, 0);
        check_eq("refill_full", w_full, 1);
        check_eq("refill_gray", w_ptr_gray, 4'hD);

        repeat (3) cycle(0, 1);
        cycle(1, 1);
        check_eq("simul_level", w_level, 5);
        check_eq("simul_afull", w_almost_full, 0);

        repeat (2) cycle(0, 1);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1);
            check_eq("wrap_level", w_level, 3);
            check_eq("wrap_full", w_full, 0);
        end

        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 99) < 45));
        end
        mid_clock_reset();
        for (int i = 0; i < 100; i++) begin
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-side pointer and flag controller for the async FIFO. It is the source end of the gray-coded pointer path that the double-flop data synchronizer carries into the read domain.
- Keeps a binary write pointer and a registered gray copy that feeds the synchronizer.
- Decodes the already-synchronized gray read pointer.
- Generates full, almost-full, fill level, memory write enable and overflow indication, all in the write clock domain.

Parameters:
PTR_WIDTH, 3, FIFO address bits; depth = 2**PTR_WIDTH; minimum 2.
AFULL_TH, 6, fill level at or above which w_almost_full asserts; range 1..2**PTR_WIDTH.

Ports:
w_clk  input  1  write-domain clock, all logic on rising edge.
w_rstn  input  1  asynchronous active-low reset.
w_inc  input  1  write request from producer.
wq2_rptr  input  PTR_WIDTH+1  gray read pointer, already synchronized into w_clk.
w_en  output  1  memory write strobe = w_inc & ~w_full (combinational).
w_addr  output  PTR_WIDTH  memory write address = low PTR_WIDTH bits of binary pointer.
w_ptr_gray  output  PTR_WIDTH+1  registered gray write pointer, to the synchronizer into the read domain.
w_full  output  1  registered full flag.
w_almost_full  output  1  registered almost-full flag.
w_level  output  PTR_WIDTH+1  registered fill level, 0..2**PTR_WIDTH.
w_ovf  output  1  one-cycle registered pulse when w_inc is seen while full.

Behaviour:
- Reset (async assert, sync release via w_rstn): binary pointer, w_ptr_gray, w_full, w_almost_full, w_level and w_ovf all go to 0. w_addr = 0, so w_en = w_inc.
- Accept condition: w_inc & ~w_full at a rising edge.
  - On accept, the binary pointer increments by 1 modulo 2**(PTR_WIDTH+1).
  - Otherwise the pointer holds.
- bin_next = bin + accept.
- gray_next = bin_next ^ (bin_next >> 1).
- w_ptr_gray <= gray_next.
  - Exactly one bit of w_ptr_gray changes per accepted write.
  - No change occurs when no write is accepted.
  - This is mandatory for safe synchronization.
- Read pointer decode (combinational): rbin = gray-to-binary of wq2_rptr, using MSB-first XOR prefix.
- w_full <= (gray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
  - The flag therefore reflects the write being accepted in the same cycle; there are no extra-cycle overwrites.
- w_level <= (bin_next - rbin) modulo 2**(PTR_WIDTH+1).
  - Max value 2**PTR_WIDTH, which coincides with w_full.
- w_almost_full <= (bin_next - rbin) >= AFULL_TH.
- w_ovf <= w_inc & w_full.
  - The rejected write does not move the pointer, w_addr or the gray output.
- Pointer wrap: the binary pointer overflows naturally at 2**(PTR_WIDTH+1). The MSB toggle distinguishes full from empty.
- Read pointer advancing in the same cycle as a write:
  - Flags use the new wq2_rptr value and bin_next.
  - Full deasserts one edge after wq2_rptr moves, unless a concurrent write refills the FIFO.
- Flags are pessimistic, because the read pointer seen here lags by the synchronizer latency. Full never deasserts early; this is correct by construction.
- Reset mid-operation: all state clears immediately. Data in memory is discarded logically. The read side is reset by its own domain reset.

Decomposition:
- Shared package fifo_pkg: functions bin2gray and gray2bin parameterized on width; constant for default PTR_WIDTH.
- One natural sub-module: gray2bin_conv (combinational, parameterized width), instantiated for wq2_rptr. It is reused later by the read-side empty controller.

Test Plan:
All scenarios use PTR_WIDTH=3 and AFULL_TH=6.
1. Reset: assert w_rstn=0 mid-clock with w_inc=1 -> all registered outputs 0 immediately; w_en=1, w_addr=0.
2. Fill: wq2_rptr=0, 8 consecutive w_inc -> w_ptr_gray steps 1,3,2,6,7,5,4,C (hex).
   - w_level steps 1..8.
   - w_almost_full asserts after the 6th accepted write.
   - w_full=1 after the 8th; w_addr wraps 7->0.
3. Overflow: continue w_inc=1 while full for 2 cycles -> w_en=0, pointer/gray held at C, w_ovf high 2 cycles then 0.
4. Drain release: from full, set wq2_rptr=1 (gray of 1) -> next edge w_full=0, w_level=7. One write is then accepted and w_full=1 again (gray D).
5. Simultaneous: level 5, w_inc=1 while wq2_rptr advances by 1 -> w_level stays 5, w_almost_full=0.
6. Wrap: run 40 write/read cycles keeping level at 3 -> w_level constant 3. Every w_ptr_gray change is single-bit (check assertion), and there is no spurious w_full through the 15->0 pointer wrap.
